// File: rtl/uart_program_loader.sv
// UART boot loader: receives an 8N1 program image, writes it into instruction
// memory one 32-bit word at a time, and holds the CPU in reset until the image
// checksum has passed. A sync byte seen while the CPU runs starts a reload.
module uart_program_loader #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_WORDS    = 4096
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        rxd,
  output logic        imemWrEn,
  output logic [11:0] imemAddress,
  output logic [31:0] imemData,
  output logic        cpuNRst,
  output logic [7:0]  loaderStatus
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, PAYLOAD, CHECK, RUN} ld_state_t;

  rx_state_t       rxState, rxNext;
  ld_state_t       ldState, ldNext;

  logic            rxdMeta, rxdSync, rxdPrev;
  logic [CW-1:0]   clkCnt;
  logic [2:0]      bitIdx;
  logic [7:0]      rxShift;
  logic            rxValid, rxFrameErr;
  logic [7:0]      rxByte;

  logic [7:0]      countLo;
  logic [15:0]     wordCount, wordsDone;
  logic [1:0]      lane;
  logic [7:0]      checksum;
  logic [4:0]      status;

  logic            halfTick, fullTick;
  logic [15:0]     countFull;
  logic            countBad, lastWord;

  assign halfTick     = (clkCnt == CW'(HALF - 1));
  assign fullTick     = (clkCnt == CW'(CLKS_PER_BIT - 1));
  assign countFull    = {rxByte, countLo};
  assign countBad     = (countFull == 16'd0) || ({1'b0, countFull} > 17'(MAX_WORDS));
  assign lastWord     = (wordsDone + 16'd1 == wordCount);
  assign loaderStatus = {3'b000, status};

  // Receiver and loader state registers.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      rxState <= RX_IDLE;
      ldState <= IDLE;
    end else begin
      rxState <= rxNext;
      ldState <= ldNext;
    end
  end

  // Receiver next state: edge-triggered start, mid-bit sampling, break wait after a bad stop bit.
  // NOTE: next state is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    rxNext = rxState;
    case (rxState)
      RX_IDLE:  if (rxdPrev && !rxdSync) rxNext = RX_START;
      RX_START: if (halfTick) rxNext = rxdSync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (fullTick && bitIdx == 3'd7) rxNext = RX_STOP;
      RX_STOP:  if (fullTick) rxNext = rxdSync ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (rxdSync) rxNext = RX_IDLE;
      default:  rxNext = RX_IDLE;
    endcase
  end

  // Receiver datapath: synchronizer, bit timing, shift register, byte/error pulses.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      rxdMeta    <= 1'b0;
      rxdSync    <= 1'b0;
      rxdPrev    <= 1'b0;
      clkCnt     <= '0;
      bitIdx     <= 3'd0;
      rxShift    <= 8'd0;
      rxValid    <= 1'b0;
      rxByte     <= 8'd0;
      rxFrameErr <= 1'b0;
    end else begin
      rxdMeta    <= rxd;
      rxdSync    <= rxdMeta;
      rxdPrev    <= rxdSync;
      rxValid    <= 1'b0;
      rxFrameErr <= 1'b0;
      if (rxState != rxNext || rxState == RX_IDLE || rxState == RX_BREAK || fullTick)
        clkCnt <= '0;
      else
        clkCnt <= clkCnt + 1'b1;
      if (rxState != RX_DATA)
        bitIdx <= 3'd0;
      else if (fullTick)
        bitIdx <= bitIdx + 3'd1;
      if (rxState == RX_DATA && fullTick)
        rxShift <= {rxdSync, rxShift[7:1]};
      if (rxState == RX_STOP && fullTick) begin
        if (rxdSync) begin
          rxValid <= 1'b1;
          rxByte  <= rxShift;
        end else begin
          rxFrameErr <= 1'b1;
        end
      end
    end
  end

  // Loader next state: walks the frame fields; only IDLE and RUN react to a sync byte.
  always_comb begin
    ldNext = ldState;
    case (ldState)
      IDLE, RUN: if (rxValid && rxByte == SYNC_BYTE) ldNext = CNT_LO;
      CNT_LO:    if (rxValid) ldNext = CNT_HI;
      CNT_HI:    if (rxValid) ldNext = countBad ? IDLE : PAYLOAD;
      PAYLOAD:   if (rxValid && lane == 2'd3 && lastWord) ldNext = CHECK;
      CHECK:     if (rxValid) ldNext = (rxByte == checksum) ? RUN : IDLE;
      default:   ldNext = IDLE;
    endcase
  end

  // Loader datapath: word assembly, memory write strobe, checksum, CPU reset and status.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      imemWrEn    <= 1'b0;
      imemAddress <= 12'd0;
      imemData    <= 32'd0;
      cpuNRst     <= 1'b0;
      status      <= 5'd0;
      countLo     <= 8'd0;
      wordCount   <= 16'd0;
      wordsDone   <= 16'd0;
      lane        <= 2'd0;
      checksum    <= 8'd0;
    end else begin
      imemWrEn <= 1'b0;
      // Address advances the cycle after each write strobe; it wraps naturally at 12 bits.
      if (imemWrEn) imemAddress <= imemAddress + 12'd1;
      if (rxFrameErr) status[3] <= 1'b1;
      if (rxValid) begin
        case (ldState)
          IDLE, RUN: begin
            if (rxByte == SYNC_BYTE) begin
              status[4]   <= 1'b0;
              status[2]   <= 1'b0;
              status[1]   <= 1'b1;
              status[0]   <= 1'b0;
              cpuNRst     <= 1'b0;
              imemAddress <= 12'd0;
              checksum    <= 8'd0;
              wordsDone   <= 16'd0;
              lane        <= 2'd0;
            end
          end
          CNT_LO: countLo <= rxByte;
          CNT_HI: begin
            wordCount <= countFull;
            if (countBad) begin
              status[4] <= 1'b1;
              status[1] <= 1'b0;
            end
          end
          PAYLOAD: begin
            imemData[{lane, 3'b000} +: 8] <= rxByte;
            checksum <= checksum ^ rxByte;
            lane     <= lane + 2'd1;
            if (lane == 2'd3) begin
              imemWrEn  <= 1'b1;
              wordsDone <= wordsDone + 16'd1;
            end
          end
          CHECK: begin
            status[1] <= 1'b0;
            if (rxByte == checksum) begin
              cpuNRst   <= 1'b1;
              status[0] <= 1'b1;
            end else begin
              status[2] <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: directed frames from the test plan plus random
// frames, all checked against a frame-level model of expected writes and status.
module tb_uart_program_loader;

  localparam int CPB = 4;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        rxd = 1'b1;
  logic        imemWrEn;
  logic [11:0] imemAddress;
  logic [31:0] imemData;
  logic        cpuNRst;
  logic [7:0]  loaderStatus;

  uart_program_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .rxd          (rxd),
    .imemWrEn     (imemWrEn),
    .imemAddress  (imemAddress),
    .imemData     (imemData),
    .cpuNRst      (cpuNRst),
    .loaderStatus (loaderStatus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          passed = 0;
  logic [43:0] obsQ[$];
  logic [43:0] expQ[$];
  int          viol = 0;
  int          rxPulses = 0;
  logic        prevWr = 1'b0;
  logic [7:0]  expStatus = 8'h00;
  logic        expCpu = 1'b0;

  // Record every write and watch the strobe/CPU-release invariants.
  always @(negedge clk) begin
    if (imemWrEn) obsQ.push_back({imemAddress, imemData});
    if (imemWrEn && (prevWr || cpuNRst)) viol++;
    prevWr = imemWrEn;
    if (dut.rxValid) rxPulses++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopBit = 1'b1);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stopBit;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input byte_q_t f);
    foreach (f[i]) send_byte(f[i]);
  endtask

  // Frame-level reference: what a complete frame starting with a sync byte
  // should write and leave in the status/CPU-reset outputs.
  task automatic model_frame(input byte_q_t f);
    int         cnt;
    logic [7:0] x;
    logic [31:0] word;
    expStatus = (expStatus & 8'h08) | 8'h02;
    expCpu    = 1'b0;
    cnt = int'(f[2]) * 256 + int'(f[1]);
    if (cnt == 0 || cnt > 4096) begin
      expStatus = (expStatus & ~8'h02) | 8'h10;
      return;
    end
    x = 8'h00;
    for (int w = 0; w < cnt; w++) begin
      word = {f[3 + 4*w + 3], f[3 + 4*w + 2], f[3 + 4*w + 1], f[3 + 4*w]};
      x = x ^ f[3 + 4*w] ^ f[3 + 4*w + 1] ^ f[3 + 4*w + 2] ^ f[3 + 4*w + 3];
      expQ.push_back({w[11:0], word});
    end
    if (f[3 + 4*cnt] == x) begin
      expCpu    = 1'b1;
      expStatus = (expStatus & ~8'h02) | 8'h01;
    end else begin
      expStatus = (expStatus & ~8'h02) | 8'h04;
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwrites"}, 64'(obsQ.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 64'(obsQ[i]), 64'(expQ[i]));
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_status"}, 64'(loaderStatus), 64'(expStatus));
    check({tag, "_cpu"}, 64'(cpuNRst), 64'(expCpu));
  endtask

  task automatic run_frame(input string tag, input byte_q_t f);
    model_frame(f);
    send_frame(f);
    compare_writes(tag);
    check_outputs(tag);
  endtask

  initial begin
    byte_q_t    f;
    int         pulsesBefore;
    int         cnt;
    logic [7:0] x;
    logic [7:0] b;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wren", 64'(imemWrEn), 64'd0);
    check("rst_addr", 64'(imemAddress), 64'd0);
    check("rst_data", 64'(imemData), 64'd0);
    check_outputs("rst");
    nRst = 1'b1;
    repeat (4) @(negedge clk);

    // Two-word load with a good checksum
    f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
          8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    run_frame("good", f);
    check("good_status_lit", 64'(loaderStatus), 64'h01);

    // Same frame, wrong checksum
    f[11] = 8'h00;
    run_frame("badchk", f);

    // Count zero and count above depth
    run_frame("cnt0", '{8'hA5, 8'h00, 8'h00});
    run_frame("cnt4097", '{8'hA5, 8'h01, 8'h10});

    // Sync byte with a low stop bit is lost and flags a framing error
    pulsesBefore = rxPulses;
    send_byte(8'hA5, 1'b0);
    expStatus = expStatus | 8'h08;
    check("frame_pulses", 64'(rxPulses - pulsesBefore), 64'd0);
    check_outputs("frame");

    // One-cycle low glitch produces nothing
    pulsesBefore = rxPulses;
    @(negedge clk);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    check("glitch_pulses", 64'(rxPulses - pulsesBefore), 64'd0);
    check_outputs("glitch");

    // Loader is back in IDLE: a full frame loads
    f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
          8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    run_frame("reload1", f);

    // Reload from RUN: CPU drops to reset on the sync byte
    f = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF};
    model_frame(f);
    send_byte(f[0]);
    check("run_sync_cpu", 64'(cpuNRst), 64'd0);
    check("run_sync_status", 64'(loaderStatus), 64'h0A);
    for (int i = 1; i < f.size(); i++) send_byte(f[i]);
    compare_writes("runreload");
    check_outputs("runreload");

    // Reset in the middle of the payload
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    nRst = 1'b0;
    @(posedge clk);
    #1;
    expStatus = 8'h00;
    expCpu    = 1'b0;
    check("midrst_wren", 64'(imemWrEn), 64'd0);
    check("midrst_addr", 64'(imemAddress), 64'd0);
    check("midrst_data", 64'(imemData), 64'd0);
    check_outputs("midrst");
    @(negedge clk);
    nRst = 1'b1;
    compare_writes("midrst");
    repeat (4) @(negedge clk);
    f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
          8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    run_frame("postrst", f);

    // Random frames, checksum good or bad
    for (int n = 0; n < 4; n++) begin
      f.delete();
      cnt = int'($urandom_range(1, 5));
      f.push_back(8'hA5);
      f.push_back(8'(cnt));
      f.push_back(8'h00);
      x = 8'h00;
      for (int i = 0; i < 4 * cnt; i++) begin
        b = 8'($urandom);
        x = x ^ b;
        f.push_back(b);
      end
      f.push_back(($urandom_range(0, 1) == 1) ? x : (x ^ 8'h5A));
      run_frame($sformatf("rand%0d", n), f);
    end

    check("invariants", 64'(viol), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
